// File: rtl/cmp_operand_sender.sv
// Feeds two 8-bit operands to the nibble-entry magnitude comparator as four paced pb/c transfers, then captures l/g/e.
// done pulses 4*(GAP+STROBE)+SETTLE edges after start is accepted; start is ignored while busy, with no queuing.
module cmp_operand_sender #(
  parameter int GAP_CYCLES    = 4,
  parameter int STROBE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  output logic       busy,
  output logic       done,
  output logic       pb1,
  output logic       pb2,
  output logic       pb3,
  output logic       pb4,
  output logic [3:0] c,
  input  logic       l_in,
  input  logic       g_in,
  input  logic       e_in,
  output logic       res_l,
  output logic       res_g,
  output logic       res_e,
  output logic       err
);

  localparam int MAX_GS = (GAP_CYCLES > STROBE_CYCLES) ? GAP_CYCLES : STROBE_CYCLES;
  localparam int MAXC   = (MAX_GS > SETTLE_CYCLES) ? MAX_GS : SETTLE_CYCLES;
  localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] GAP_LD    = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, SETTLE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    a_q, b_q;
  logic [3:0]    c_q, c_d;
  logic [3:0]    pb_q, pb_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [2:0]    res_q;
  logic          err_q;
  logic          load;
  logic          capture;
  logic          one_hot;

  function automatic logic [3:0] nibble(input logic [7:0] a, input logic [7:0] b,
                                        input logic [1:0] idx);
    case (idx)
      2'd0:    nibble = a[3:0];
      2'd1:    nibble = a[7:4];
      2'd2:    nibble = b[3:0];
      default: nibble = b[7:4];
    endcase
  endfunction

  // exactly one of three: odd parity rules out two-hot, the AND rules out all three
  assign one_hot = (l_in ^ g_in ^ e_in) & ~(l_in & g_in & e_in);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    pb_d    = pb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          busy_d  = 1'b1;
          c_d     = a_in[3:0];
          idx_d   = 2'd0;
          cnt_d   = GAP_LD;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          pb_d    = 4'b0001 << idx_q;
          cnt_d   = STROBE_LD;
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          pb_d = 4'b0000;
          if (idx_q == 2'd3) begin
            cnt_d   = SETTLE_LD;
            state_d = SETTLE;
          end else begin
            // next nibble lands on c the same edge the strobe falls
            idx_d   = idx_q + 2'd1;
            c_d     = nibble(a_q, b_q, idx_q + 2'd1);
            cnt_d   = GAP_LD;
            state_d = SETUP;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      c_q     <= 4'h0;
      pb_q    <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= 3'b000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      pb_q    <= pb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (load) begin
        a_q <= a_in;
        b_q <= b_in;
      end
      if (capture) begin
        res_q <= {l_in, g_in, e_in};
        err_q <= ~one_hot;
      end
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign pb1   = pb_q[0];
  assign pb2   = pb_q[1];
  assign pb3   = pb_q[2];
  assign pb4   = pb_q[3];
  assign c     = c_q;
  assign res_l = res_q[2];
  assign res_g = res_q[1];
  assign res_e = res_q[0];
  assign err   = err_q;

endmodule

// File: tb/tb_cmp_operand_sender.sv
// Bench for cmp_operand_sender: a default-parameter instance and a 1/1/1 instance, each
// driving a behavioural nibble-entry comparator that loads its registers from pb/c.
module tb_cmp_operand_sender;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic       start [2];
  logic [7:0] a_in [2];
  logic [7:0] b_in [2];
  logic       busy [2];
  logic       done [2];
  logic [3:0] cv [2];
  logic       rl [2];
  logic       rg [2];
  logic       re [2];
  logic       er [2];
  logic       d0_pb1, d0_pb2, d0_pb3, d0_pb4;
  logic       d1_pb1, d1_pb2, d1_pb3, d1_pb4;
  logic [3:0] pbv [2];
  logic       l0, g0, e0, l1, g1, e1;

  // comparator model registers and optional override of its outputs (instance 0 only)
  logic [7:0] ma [2] = '{default: 8'h00};
  logic [7:0] mb [2] = '{default: 8'h00};
  logic       frc = 1'b0, f_l = 1'b0, f_g = 1'b0, f_e = 1'b0;

  assign pbv[0] = {d0_pb4, d0_pb3, d0_pb2, d0_pb1};
  assign pbv[1] = {d1_pb4, d1_pb3, d1_pb2, d1_pb1};
  assign l0 = frc ? f_l : (ma[0] < mb[0]);
  assign g0 = frc ? f_g : (ma[0] > mb[0]);
  assign e0 = frc ? f_e : (ma[0] == mb[0]);
  assign l1 = ma[1] < mb[1];
  assign g1 = ma[1] > mb[1];
  assign e1 = ma[1] == mb[1];

  cmp_operand_sender dut0 (
    .clk(clk), .rstn(rstn), .start(start[0]), .a_in(a_in[0]), .b_in(b_in[0]),
    .busy(busy[0]), .done(done[0]),
    .pb1(d0_pb1), .pb2(d0_pb2), .pb3(d0_pb3), .pb4(d0_pb4), .c(cv[0]),
    .l_in(l0), .g_in(g0), .e_in(e0),
    .res_l(rl[0]), .res_g(rg[0]), .res_e(re[0]), .err(er[0])
  );

  cmp_operand_sender #(.GAP_CYCLES(1), .STROBE_CYCLES(1), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rstn(rstn), .start(start[1]), .a_in(a_in[1]), .b_in(b_in[1]),
    .busy(busy[1]), .done(done[1]),
    .pb1(d1_pb1), .pb2(d1_pb2), .pb3(d1_pb3), .pb4(d1_pb4), .c(cv[1]),
    .l_in(l1), .g_in(g1), .e_in(e1),
    .res_l(rl[1]), .res_g(rg[1]), .res_e(re[1]), .err(er[1])
  );

  // monitor state, sampled on the falling edge
  int         nsamp = 0;
  int         pulses [2][4] = '{default: 0};
  int         hi_cnt [2][4] = '{default: 0};
  int         rise_at [2][4] = '{default: 0};
  int         c_bad [2] = '{default: 0};
  int         multi [2] = '{default: 0};
  int         done_cnt [2] = '{default: 0};
  logic [3:0] pprev [2] = '{default: 4'h0};
  int         t0 [2] = '{default: 0};
  logic [7:0] exp_a [2] = '{default: 8'h00};
  logic [7:0] exp_b [2] = '{default: 8'h00};

  // snapshots taken when a transaction is accepted
  int sp [2][4];
  int sh [2][4];
  int sc [2];
  int sm [2];
  int sd [2];

  int ncmp = 0;
  int nfail = 0;

  function automatic logic [3:0] nib(input logic [7:0] a, input logic [7:0] b, input int i);
    logic [15:0] ops;
    ops = {b, a};
    return ops[i*4 +: 4];
  endfunction

  always @(negedge clk) begin
    nsamp <= nsamp + 1;
    for (int d = 0; d < 2; d++) begin
      if ($countones(pbv[d]) > 1) multi[d] <= multi[d] + 1;
      if (done[d]) done_cnt[d] <= done_cnt[d] + 1;
      for (int i = 0; i < 4; i++) begin
        if (pbv[d][i]) begin
          hi_cnt[d][i] <= hi_cnt[d][i] + 1;
          if (cv[d] !== nib(exp_a[d], exp_b[d], i)) c_bad[d] <= c_bad[d] + 1;
          if (!pprev[d][i]) begin
            pulses[d][i]  <= pulses[d][i] + 1;
            rise_at[d][i] <= nsamp - t0[d];
            case (i)
              0:       ma[d][3:0] <= cv[d];
              1:       ma[d][7:4] <= cv[d];
              2:       mb[d][3:0] <= cv[d];
              default: mb[d][7:4] <= cv[d];
            endcase
          end
        end
      end
      pprev[d] <= pbv[d];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input int d, input logic [7:0] a, input logic [7:0] b);
    a_in[d]  = a;
    b_in[d]  = b;
    exp_a[d] = a;
    exp_b[d] = b;
    start[d] = 1'b1;
    @(posedge clk);
    #1;
    t0[d]    = nsamp;
    start[d] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sp[d][i] = pulses[d][i];
      sh[d][i] = hi_cnt[d][i];
    end
    sc[d] = c_bad[d];
    sm[d] = multi[d];
    sd[d] = done_cnt[d];
    chk("busy_after_start", busy[d], 1);
  endtask

  task automatic finish_txn(input int d, input int exp_edge, input int gap, input int stb,
                            input logic xl, input logic xg, input logic xe);
    int  k;
    bit  got;
    int  edge_no;
    k = 0;
    got = 0;
    while (!got && k < 400) begin
      @(posedge clk);
      #1;
      k++;
      if (done[d] === 1'b1) got = 1;
    end
    edge_no = got ? (nsamp - t0[d]) : -1;
    chk("done_edge", edge_no, exp_edge);
    chk("busy_at_done", busy[d], 0);
    chk("res_l", rl[d], xl);
    chk("res_g", rg[d], xg);
    chk("res_e", re[d], xe);
    chk("err", er[d], (int'(xl) + int'(xg) + int'(xe)) != 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pb%0d_pulses", i + 1), pulses[d][i] - sp[d][i], 1);
      chk($sformatf("pb%0d_high_cycles", i + 1), hi_cnt[d][i] - sh[d][i], stb);
      chk($sformatf("pb%0d_rise_edge", i + 1), rise_at[d][i], gap + i * (gap + stb));
    end
    chk("c_stable_during_strobe", c_bad[d] - sc[d], 0);
    chk("strobe_overlap", multi[d] - sm[d], 0);
    chk("model_a", ma[d], exp_a[d]);
    chk("model_b", mb[d], exp_b[d]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] ra, rb;
    int         k;
    rstn  = 1'b0;
    start = '{default: 1'b0};
    a_in  = '{default: 8'h00};
    b_in  = '{default: 8'h00};
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", busy[d], 0);
      chk("rst_done", done[d], 0);
      chk("rst_pb", pbv[d], 0);
      chk("rst_c", cv[d], 0);
      chk("rst_res", {rl[d], rg[d], re[d], er[d]}, 0);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // nibble order and greater-than result
    launch(0, 8'h5A, 8'h3C);
    finish_txn(0, 34, 4, 4, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("done_one_cycle", done[0], 0);
    chk("c_holds_in_idle", cv[0], 4'h3);

    // operands latched at start
    launch(0, 8'hF0, 8'hF0);
    a_in[0] = 8'h00;
    finish_txn(0, 34, 4, 4, 1'b0, 1'b0, 1'b1);

    // start while busy is ignored; start during done launches back-to-back
    launch(0, 8'h12, 8'h34);
    repeat (9) @(posedge clk);
    #1;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    finish_txn(0, 34, 4, 4, 1'b1, 1'b0, 1'b0);
    launch(0, 8'hC3, 8'h3C);
    finish_txn(0, 34, 4, 4, 1'b0, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("single_done_pulse", done_cnt[0] - sd[0], 1);

    // asynchronous reset while pb2 is high
    launch(0, 8'h77, 8'h11);
    k = 0;
    while (d0_pb2 !== 1'b1 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("pb2_reached", d0_pb2, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_pb2", d0_pb2, 0);
    chk("arst_busy", busy[0], 0);
    chk("arst_c", cv[0], 0);
    chk("arst_res", {rl[0], rg[0], re[0], er[0]}, 0);
    sd[0] = done_cnt[0];
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("no_done_after_abort", done_cnt[0] - sd[0], 0);
    chk("res_stay_zero", {rl[0], rg[0], re[0], er[0]}, 0);
    launch(0, 8'h21, 8'h21);
    finish_txn(0, 34, 4, 4, 1'b0, 1'b0, 1'b1);

    // invalid comparator outputs
    frc = 1'b1; f_l = 1'b1; f_g = 1'b1; f_e = 1'b0;
    launch(0, 8'h10, 8'h20);
    finish_txn(0, 34, 4, 4, 1'b1, 1'b1, 1'b0);
    f_l = 1'b0; f_g = 1'b0; f_e = 1'b0;
    launch(0, 8'h44, 8'h45);
    finish_txn(0, 34, 4, 4, 1'b0, 1'b0, 1'b0);
    frc = 1'b0;

    // randomized operands, expected result from plain magnitude compare
    for (int it = 0; it < 6; it++) begin
      ra = 8'($urandom);
      rb = (it % 3 == 0) ? ra : 8'($urandom);
      launch(0, ra, rb);
      finish_txn(0, 34, 4, 4, ra < rb, ra > rb, ra == rb);
    end

    // minimum timing parameters
    launch(1, 8'h80, 8'h7F);
    finish_txn(1, 9, 1, 1, 1'b0, 1'b1, 1'b0);
    for (int it = 0; it < 3; it++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      launch(1, ra, rb);
      finish_txn(1, 9, 1, 1, ra < rb, ra > rb, ra == rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
